// File: rtl/vga_pkg.sv
// Shared VGA raster types and default 640x480@60 timing constants.
package vga_pkg;

   typedef logic [9:0] pos_t;

   localparam int unsigned H_DISPLAY_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_DISPLAY_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   localparam int unsigned H_TOTAL_DEF =
      H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int unsigned V_TOTAL_DEF =
      V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
      return (pos >= lo) && (pos <= hi);
   endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock by CLK_DIV; tick_o marks the last clock of each pixel.
module pixel_tick_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic tick_o
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CLK_DIV == 0) begin : g_bad_div
      $error("pixel_tick_gen: CLK_DIV must be at least 1");
   end

   logic [DIV_W-1:0] r_div;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_div <= '0;
      end else if (r_div == DIV_LAST) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Gating with reset keeps the tick low in reset even when CLK_DIV=1.
   assign tick_o = reset_i & (r_div == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: position counters, registered sync/blanking, line/frame strobes.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_DISPLAY        = H_DISPLAY_DEF,
   parameter int unsigned H_FRONT          = H_FRONT_DEF,
   parameter int unsigned H_SYNC           = H_SYNC_DEF,
   parameter int unsigned H_BACK           = H_BACK_DEF,
   parameter int unsigned V_DISPLAY        = V_DISPLAY_DEF,
   parameter int unsigned V_FRONT          = V_FRONT_DEF,
   parameter int unsigned V_SYNC           = V_SYNC_DEF,
   parameter int unsigned V_BACK           = V_BACK_DEF,
   parameter int unsigned CLK_DIV          = 2,
   parameter bit          SYNC_ACTIVE_HIGH = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   output pos_t hpos_o,
   output pos_t vpos_o,
   output logic hsync_o,
   output logic vsync_o,
   output logic display_on_o,
   output logic pixel_tick_o,
   output logic line_start_o,
   output logic frame_start_o
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
   localparam pos_t V_LAST   = pos_t'(V_TOTAL - 1);
   localparam pos_t H_VIS    = pos_t'(H_DISPLAY);
   localparam pos_t V_VIS    = pos_t'(V_DISPLAY);
   localparam pos_t HS_FIRST = pos_t'(H_DISPLAY + H_FRONT);
   localparam pos_t HS_LAST  = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam pos_t VS_FIRST = pos_t'(V_DISPLAY + V_FRONT);
   localparam pos_t VS_LAST  = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic w_tick;
   pos_t r_hpos;
   pos_t r_vpos;
   pos_t w_hpos_next;
   pos_t w_vpos_next;
   logic r_hsync;
   logic r_vsync;
   logic r_display_on;
   logic w_hs_act;
   logic w_vs_act;
   logic w_de;

   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_tick_gen (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .tick_o  (w_tick)
   );

   always_comb begin
      w_hpos_next = r_hpos;
      w_vpos_next = r_vpos;
      if (w_tick) begin
         if (r_hpos == H_LAST) begin
            w_hpos_next = '0;
            w_vpos_next = (r_vpos == V_LAST) ? '0 : r_vpos + 1'b1;
         end else begin
            w_hpos_next = r_hpos + 1'b1;
         end
      end
   end

   // Decode from next-state so the registered flags line up with the registered position.
   always_comb begin
      w_hs_act = in_window(w_hpos_next, HS_FIRST, HS_LAST);
      w_vs_act = in_window(w_vpos_next, VS_FIRST, VS_LAST);
      w_de     = (w_hpos_next < H_VIS) && (w_vpos_next < V_VIS);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_hpos       <= '0;
         r_vpos       <= '0;
         r_hsync      <= ~SYNC_ACTIVE_HIGH;
         r_vsync      <= ~SYNC_ACTIVE_HIGH;
         r_display_on <= 1'b0;
      end else begin
         r_hpos       <= w_hpos_next;
         r_vpos       <= w_vpos_next;
         r_hsync      <= w_hs_act ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
         r_vsync      <= w_vs_act ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
         r_display_on <= w_de;
      end
   end

   assign hpos_o        = r_hpos;
   assign vpos_o        = r_vpos;
   assign hsync_o       = r_hsync;
   assign vsync_o       = r_vsync;
   assign display_on_o  = r_display_on;
   assign pixel_tick_o  = w_tick;
   assign line_start_o  = w_tick & (r_hpos == '0);
   assign frame_start_o = line_start_o & (r_vpos == '0);

endmodule
